lzx_cmp_serial: RTL and testbench
=================================

// Module: lzx_cmp_serial
// PURPOSE
//   Sequential wide-word magnitude comparator built around a 4-bit compare slice
//   with cascade (gt/eq/lt) semantics. Accepts two WIDTH-bit operands over a
//   valid/ready handshake and walks them MSB-nibble first, one nibble per clock.
//   It carries the cascade state between cycles and exits early on the first
//   unequal nibble. Sits upstream of downstream control logic and returns one
//   registered gt/eq/lt verdict per transaction.
// PARAMETERS
//   WIDTH  16  operand width in bits; must be a multiple of 4 and >= 4
//   NIB    WIDTH/4 (localparam)  nibbles per operand
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      operand pair a/b presented
//   in_ready   out  1      block can accept operands (high only in IDLE)
//   a          in   WIDTH  operand A (unsigned)
//   b          in   WIDTH  operand B (unsigned)
//   out_valid  out  1      verdict on gt/eq/lt is valid
//   out_ready  in   1      consumer accepts verdict
//   gt         out  1      A > B
//   eq         out  1      A == B
//   lt         out  1      A < B
//   busy       out  1      high in RUN or DONE
// BEHAVIOUR
//   Reset: async, active-high. State -> IDLE. out_valid, gt, eq, lt, busy = 0.
//     in_ready = 1 once rst deasserts. Shift regs and counter = 0.
//   FSM states: IDLE, RUN, DONE.
//   IDLE: in_ready=1. On edge with in_valid=1:
//     - capture a and b into shift regs sa and sb.
//     - cascade state = (g=0, e=1, l=0); nibble counter = NIB-1.
//     - clear gt/eq/lt; go to RUN.
//   RUN: each edge compares sa[WIDTH-1:WIDTH-4] with sb[WIDTH-1:WIDTH-4].
//     - cascade priority g > l > e, matching the 4-bit slice.
//     - upper nibble of A greater -> g=1, e=0; upper nibble of A less -> l=1, e=0;
//       nibbles equal -> state unchanged.
//     - sa and sb shift left 4 bits with zero fill; counter decrements.
//     - Leave for DONE on the same edge when the updated state has g|l set (early
//       exit) or when counter was 0. On that edge load gt/eq/lt from the updated state.
//   DONE: out_valid=1. gt/eq/lt held stable; exactly one is high.
//     - On edge with out_ready=1: out_valid->0, gt/eq/lt->0, go to IDLE.
//     - in_ready=0 in DONE. A new transaction needs at least one IDLE cycle.
//   Latency: handshake at edge t -> out_valid rises at edge t+k.
//     - k = 1-based index, from the MSB, of the first differing nibble.
//     - k = NIB when the operands are equal.
//   in_valid while in RUN or DONE is ignored. a/b are sampled only at acceptance.
//   out_ready while not in DONE has no effect.
//   Reset asserted mid-RUN or mid-DONE aborts immediately. The in-flight result
//     is discarded and never presented.
//   WIDTH=4: single RUN cycle, k=1 always.
// TESTING (WIDTH=16)
//   A=0x1234,B=0x1234 accepted at edge t, out_ready=1 -> eq=1,gt=lt=0, out_valid
//     rises at t+4 and is high one cycle, then in_ready=1.
//   A=0x9000,B=0x1FFF -> gt=1 at t+1 (early exit on MSB nibble).
//   A=0x12A4,B=0x12B4 -> lt=1 at t+3; low-nibble equality ignored.
//   A=0xFFFF,B=0x0000, out_ready=0 for 10 cycles while in_valid=1, a/b change ->
//     gt,out_valid stable, in_ready=0. Releasing out_ready -> IDLE, fresh accept.
//   A=0x0001,B=0x0002 accepted, rst pulsed at t+2 -> outputs 0, IDLE.
//     Then A=0x0003,B=0x0003 -> eq at t'+4, no stale lt.
//   Back-to-back: 0x8000 vs 0x7FFF then 0x7FFF vs 0x8000 with in_valid held ->
//     gt at t+1, then lt on the next transaction; exactly one flag high per verdict.

Source files
------------

// File: rtl/lzx_cmp_serial.sv
// Serial wide-word magnitude comparator: walks two WIDTH-bit operands MSB nibble
// first through a 4-bit cascade slice, exiting early on the first unequal nibble.
module lzx_cmp_serial #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic             busy
);

    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [CW-1:0]    cnt_q;
    logic             g_q, e_q, l_q;
    logic             gt_q, eq_q, lt_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic             g_d, e_d, l_d;
    logic             exit_d;

    // One cascade slice step; an already-decided g or l takes priority over the nibble.
    always_comb begin
        a_nib = sa_q[WIDTH-1 -: 4];
        b_nib = sb_q[WIDTH-1 -: 4];
        g_d   = g_q;
        e_d   = e_q;
        l_d   = l_q;
        if (!g_q && !l_q) begin
            if (a_nib > b_nib) begin
                g_d = 1'b1;
                e_d = 1'b0;
            end else if (a_nib < b_nib) begin
                l_d = 1'b1;
                e_d = 1'b0;
            end
        end
        exit_d = g_d | l_d | (cnt_q == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sa_q        <= '0;
            sb_q        <= '0;
            cnt_q       <= '0;
            g_q         <= 1'b0;
            e_q         <= 1'b0;
            l_q         <= 1'b0;
            gt_q        <= 1'b0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        g_q     <= 1'b0;
                        e_q     <= 1'b1;
                        l_q     <= 1'b0;
                        cnt_q   <= CW'(NIB - 1);
                        gt_q    <= 1'b0;
                        eq_q    <= 1'b0;
                        lt_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sa_q  <= sa_q << 4;
                    sb_q  <= sb_q << 4;
                    cnt_q <= cnt_q - CW'(1);
                    g_q   <= g_d;
                    e_q   <= e_d;
                    l_q   <= l_d;
                    if (exit_d) begin
                        gt_q        <= g_d;
                        eq_q        <= e_d;
                        lt_q        <= l_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        gt_q        <= 1'b0;
                        eq_q        <= 1'b0;
                        lt_q        <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Ready tracks the idle state but stays low while reset is held.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign gt        = gt_q;
    assign eq        = eq_q;
    assign lt        = lt_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_lzx_cmp_serial.sv
// Self-checking bench for lzx_cmp_serial (WIDTH=16) against an arithmetic reference model.
module tb_lzx_cmp_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic        gt, eq, lt, busy;

    int total = 0;
    int bad   = 0;

    lzx_cmp_serial #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .gt(gt), .eq(eq), .lt(lt), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: verdict from plain magnitude compare, latency from first differing nibble.
    function automatic void model(input logic [15:0] x, input logic [15:0] y,
                                  output int k, output logic [2:0] gel);
        logic found;
        found = 1'b0;
        k = 4;
        for (int i = 0; i < 4; i++) begin
            if (!found && (((x >> (12 - 4*i)) & 16'hF) != ((y >> (12 - 4*i)) & 16'hF))) begin
                k = i + 1;
                found = 1'b1;
            end
        end
        gel = {x > y, x == y, x < y};
    endfunction

    // One full transaction: accept, wait for the verdict, stall `hold` cycles, release.
    task automatic do_txn(input logic [15:0] ta, input logic [15:0] tb_v, input int hold,
                          input string name);
        int       n;
        int       k;
        logic [2:0] gel;
        model(ta, tb_v, k, gel);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL %s ready_timeout in_ready=%0b want=1", name, in_ready);
        end
        a = ta; b = tb_v; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n !== k) begin
            bad++;
            $display("FAIL %s latency got=%0d want=%0d (a=%h b=%h)", name, n, k, ta, tb_v);
        end
        total++;
        if ({gt, eq, lt} !== gel || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s verdict got=%b/%b want=%b/1 (a=%h b=%h)", name, {gt, eq, lt},
                     out_valid, gel, ta, tb_v);
        end
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s done_flags in_ready=%b busy=%b want 0/1", name, in_ready, busy);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom); in_valid = 1'b1;
            @(posedge clk); #1;
            total++;
            if ({gt, eq, lt} !== gel || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL %s hold%0d got=%b ov=%b ir=%b want=%b ov=1 ir=0", name, i,
                         {gt, eq, lt}, out_valid, in_ready, gel);
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || {gt, eq, lt} !== 3'b000) begin
            bad++;
            $display("FAIL %s release ov=%b ir=%b busy=%b flags=%b want 0/1/0/000", name,
                     out_valid, in_ready, busy, {gt, eq, lt});
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({out_valid, gt, eq, lt, busy, in_ready} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=000000", {out_valid, gt, eq, lt, busy, in_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b want=1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_txn(16'h1234, 16'h1234, 0, "eq_full");
        do_txn(16'h9000, 16'h1FFF, 0, "gt_msb");
        do_txn(16'h12A4, 16'h12B4, 0, "lt_nib3");
        do_txn(16'h0000, 16'h0000, 0, "zero_eq");
        do_txn(16'hFFFE, 16'hFFFF, 0, "lt_lsb");
    endtask

    task automatic test_hold();
        do_txn(16'hFFFF, 16'h0000, 10, "hold_gt");
        do_txn(16'h5555, 16'h5555, 2, "fresh_after_hold");
    endtask

    task automatic test_reset_abort();
        a = 16'h0001; b = 16'h0002; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total++;
        if ({out_valid, gt, eq, lt, busy, in_ready} !== 6'b0) begin
            bad++;
            $display("FAIL abort_outputs got=%b want=000000", {out_valid, gt, eq, lt, busy, in_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL abort_stale ov=%b ir=%b want 0/1", out_valid, in_ready);
            end
        end
        @(negedge clk);
        do_txn(16'h0003, 16'h0003, 0, "post_abort_eq");
    endtask

    task automatic test_back_to_back();
        int n;
        a = 16'h8000; b = 16'h7FFF; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || {gt, eq, lt} !== 3'b100) begin
            bad++;
            $display("FAIL b2b_first ov=%b flags=%b want 1/100", out_valid, {gt, eq, lt});
        end
        @(negedge clk);
        a = 16'h7FFF; b = 16'h8000;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_gap ov=%b ir=%b want 0/1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n !== 1 || {gt, eq, lt} !== 3'b001) begin
            bad++;
            $display("FAIL b2b_second lat=%0d flags=%b want 1/001", n, {gt, eq, lt});
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_release ov=%b ir=%b want 0/1", out_valid, in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [15:0] x, y;
        int          p;
        for (int t = 0; t < 40; t++) begin
            x = 16'($urandom);
            p = int'($urandom_range(0, 4));
            // Share the top nibbles so every latency value gets exercised.
            if (p == 4) y = x;
            else y = x ^ (16'(1 + $urandom_range(0, 14)) << (12 - 4*p));
            if ($urandom_range(0, 1) == 1) y = 16'($urandom);
            do_txn(x, y, int'($urandom_range(0, 3)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
